// File: rtl/ad9643_spi_pkg.sv
// Shared types and constants for the AD9643 3-wire SPI initiator.
// Frame layout: {rw, W1W0, addr[12:0], data[7:0]}, MSB first.
package ad9643_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int FRAME_BITS = 24;
    localparam int INSTR_BITS = 16;
    localparam int ADDR_BITS  = 13;
    localparam int DATA_BITS  = 8;

    localparam logic [1:0] W1W0_ONE_BYTE = 2'b00;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        return {rw, W1W0_ONE_BYTE, addr, data};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ad9643_spi_clkgen.sv
// sclk phase generator: CLK_DIV cycles low, CLK_DIV cycles high.
// Strobes flag the cycle before sclk toggles; idles low when disabled.
module ad9643_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick;

    assign tick = en && (cnt_q == CW'(CLK_DIV - 1));
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // Phase counter and sclk toggle; parked low whenever not shifting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (tick) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ad9643_spi_master.sv
// AD9643 3-wire SPI initiator: one 24-bit register access per command.
// All pin and handshake outputs come straight from flops.
module ad9643_spi_master
    import ad9643_spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int CSB_SETUP = 2,
    parameter int CSB_HOLD  = 2,
    parameter int CSB_IDLE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rw,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 csb,
    output logic                 sclk,
    output logic                 sdio_o,
    output logic                 sdio_oe,
    input  logic                 sdio_i
);

    localparam int CNT_MAX = max3(CSB_SETUP, CSB_HOLD, CSB_IDLE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int NB_W    = $clog2(FRAME_BITS + 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NB_W-1:0]        nbits_q, nbits_d;
    logic [FRAME_BITS-1:0]  sh_q, sh_d;
    logic                   rw_q, rw_d;
    logic [DATA_BITS-1:0]   rd_q, rd_d;

    logic                   csb_d;
    logic                   sdio_o_d;
    logic                   sdio_oe_d;
    logic                   rsp_valid_d;
    logic [DATA_BITS-1:0]   rsp_rdata_d;
    logic                   busy_d;
    logic                   cmd_ready_d;

    logic                   rise;
    logic                   fall;

    ad9643_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == SHIFT),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbits_d     = nbits_q;
        sh_d        = sh_q;
        rw_d        = rw_q;
        rd_d        = rd_q;
        csb_d       = csb;
        sdio_o_d    = sdio_o;
        sdio_oe_d   = sdio_oe;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        busy_d      = busy;
        cmd_ready_d = cmd_ready;

        unique case (state_q)
            IDLE: begin
                csb_d       = 1'b1;
                sdio_oe_d   = 1'b0;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    state_d     = SETUP;
                    cnt_d       = '0;
                    nbits_d     = '0;
                    rw_d        = cmd_rw;
                    rd_d        = '0;
                    sh_d        = build_frame(cmd_rw, cmd_addr,
                                              cmd_rw ? '0 : cmd_wdata);
                    csb_d       = 1'b0;
                    sdio_oe_d   = 1'b1;
                    sdio_o_d    = cmd_rw;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CSB_SETUP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (rise && rw_q && nbits_q >= NB_W'(INSTR_BITS)) begin
                    rd_d = {rd_q[DATA_BITS-2:0], sdio_i};
                end
                if (fall) begin
                    sh_d = sh_q << 1;
                    if (nbits_q == NB_W'(FRAME_BITS - 1)) begin
                        state_d   = HOLD;
                        cnt_d     = '0;
                        sdio_oe_d = 1'b0;
                        sdio_o_d  = 1'b0;
                    end else begin
                        nbits_d  = nbits_q + 1'b1;
                        sdio_o_d = sh_q[FRAME_BITS-2];
                        if (rw_q && nbits_q == NB_W'(INSTR_BITS - 1)) begin
                            sdio_oe_d = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CSB_HOLD - 1)) begin
                    state_d     = GAP;
                    cnt_d       = '0;
                    csb_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rw_q ? rd_q : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CSB_IDLE - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nbits_q   <= '0;
            sh_q      <= '0;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            csb       <= 1'b1;
            sdio_o    <= 1'b0;
            sdio_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nbits_q   <= nbits_d;
            sh_q      <= sh_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            csb       <= csb_d;
            sdio_o    <= sdio_o_d;
            sdio_oe   <= sdio_oe_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            busy      <= busy_d;
            cmd_ready <= cmd_ready_d;
        end
    end

endmodule

// File: tb/tb_ad9643_spi_master.sv
// Bench for ad9643_spi_master: AD9643-style responder, frame monitor,
// transaction queue model and directed command sequence.
module tb_ad9643_spi_master;

    localparam int CLK_DIV   = 4;
    localparam int CSB_SETUP = 2;
    localparam int CSB_HOLD  = 2;
    localparam int CSB_IDLE  = 4;
    localparam int LOW_CYC   = CSB_SETUP + 48 * CLK_DIV + CSB_HOLD;

    typedef struct {
        logic        rw;
        logic [12:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [12:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        csb;
    logic        sclk;
    logic        sdio_o;
    logic        sdio_oe;
    logic        sdio_i;

    logic        c1_valid = 1'b0;
    logic        c1_ready;
    logic        c1_rw = 1'b0;
    logic [12:0] c1_addr = '0;
    logic [7:0]  c1_wdata = '0;
    logic        c1_rsp_valid;
    logic [7:0]  c1_rsp_rdata;
    logic        c1_busy;
    logic        c1_csb;
    logic        c1_sclk;
    logic        c1_sdio_o;
    logic        c1_sdio_oe;
    logic        c1_sdio_i = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ad9643_spi_master #(
        .CLK_DIV   (CLK_DIV),
        .CSB_SETUP (CSB_SETUP),
        .CSB_HOLD  (CSB_HOLD),
        .CSB_IDLE  (CSB_IDLE)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .csb       (csb),
        .sclk      (sclk),
        .sdio_o    (sdio_o),
        .sdio_oe   (sdio_oe),
        .sdio_i    (sdio_i)
    );

    ad9643_spi_master #(
        .CLK_DIV   (1),
        .CSB_SETUP (CSB_SETUP),
        .CSB_HOLD  (CSB_HOLD),
        .CSB_IDLE  (CSB_IDLE)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (c1_valid),
        .cmd_ready (c1_ready),
        .cmd_rw    (c1_rw),
        .cmd_addr  (c1_addr),
        .cmd_wdata (c1_wdata),
        .rsp_valid (c1_rsp_valid),
        .rsp_rdata (c1_rsp_rdata),
        .busy      (c1_busy),
        .csb       (c1_csb),
        .sclk      (c1_sclk),
        .sdio_o    (c1_sdio_o),
        .sdio_oe   (c1_sdio_oe),
        .sdio_i    (c1_sdio_i)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Register contents the responder returns on reads.
    function automatic logic [7:0] rd_value(input logic [12:0] a);
        return (a == 13'h001) ? 8'h82 : (a[7:0] ^ 8'hA5);
    endfunction

    // AD9643-side responder: decodes the instruction, drives read data
    // on sclk falling edges once the 16 instruction bits are in.
    logic        r_oe = 1'b0;
    logic        r_bit = 1'b0;
    logic        r_prev = 1'b0;
    int          r_cnt = 0;
    logic [15:0] r_instr = '0;
    logic [7:0]  r_byte = '0;

    assign sdio_i = r_oe ? r_bit : 1'b0;

    always @(negedge clk) begin
        if (!rst_n || csb) begin
            r_cnt = 0;
            r_oe = 1'b0;
            r_instr = '0;
        end else begin
            if (sclk && !r_prev) begin
                if (r_cnt < 16) r_instr = {r_instr[14:0], sdio_o};
                r_cnt++;
            end
            if (!sclk && r_prev) begin
                if (r_cnt >= 16 && r_cnt < 24 && r_instr[15]) begin
                    if (r_cnt == 16) r_byte = rd_value(r_instr[12:0]);
                    r_bit = r_byte[23 - r_cnt];
                    r_oe = 1'b1;
                end else if (r_cnt >= 24) begin
                    r_oe = 1'b0;
                end
            end
        end
        r_prev = sclk;
    end

    // Frame monitor and scoreboard compare.
    txn_t        exp_q[$];
    txn_t        e;
    logic        prev_csb = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_sdio = 1'b0;
    logic        prev_rstn = 1'b0;
    logic        fe;
    int          high_run = CSB_IDLE;
    int          m_low = 0;
    int          m_rises = 0;
    logic [23:0] m_frame = '0;
    logic [23:0] m_oe = '0;
    logic [23:0] last_frame = '0;
    int          last_low = 0;
    int          last_rises = 0;
    logic [7:0]  last_rdata = '0;
    int          rsp_count = 0;

    logic        c1_prev_csb = 1'b1;
    logic        c1_prev_sclk = 1'b0;
    logic        c1_fe;
    int          c1_low = 0;
    int          c1_rises = 0;
    logic [23:0] c1_frame = '0;
    logic [23:0] c1_last_frame = '0;
    int          c1_last_low = 0;
    int          c1_last_rises = 0;
    logic [7:0]  c1_last_rdata = '0;
    int          c1_rsp_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            high_run = CSB_IDLE;
            m_low = 0;
            m_rises = 0;
        end else if (prev_rstn) begin
            chk("busy_vs_ready", busy, !cmd_ready);
            chk("contention", r_oe & sdio_oe, 0);
            if (csb) begin
                chk("sclk_idle_low", sclk, 0);
                chk("oe_idle_low", sdio_oe, 0);
            end
            if (!csb && !prev_csb) begin
                chk("sdio_change_off_fall",
                    (sdio_o != prev_sdio) && !(prev_sclk && !sclk), 0);
            end
            fe = csb && !prev_csb;
            if (!csb) begin
                if (prev_csb) begin
                    chk("csb_idle_gap", high_run >= CSB_IDLE, 1);
                    m_low = 0;
                    m_rises = 0;
                    m_frame = '0;
                    m_oe = '0;
                end
                m_low++;
                if (sclk && !prev_sclk) begin
                    m_frame = {m_frame[22:0], sdio_o};
                    m_oe = {m_oe[22:0], sdio_oe};
                    m_rises++;
                end
                high_run = 0;
            end else begin
                high_run++;
            end
            chk("rsp_valid_at_frame_end", rsp_valid, fe);
            if (fe) begin
                last_frame = m_frame;
                last_low = m_low;
                last_rises = m_rises;
                last_rdata = rsp_rdata;
                rsp_count++;
                chk("frame_was_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("frame_instr", m_frame[23:8], {e.rw, 2'b00, e.addr});
                    if (!e.rw) chk("frame_wdata", m_frame[7:0], e.wdata);
                    chk("frame_rises", m_rises, 24);
                    chk("csb_low_cycles", m_low, LOW_CYC);
                    chk("oe_pattern", m_oe,
                        e.rw ? 24'hFFFF00 : 24'hFFFFFF);
                    chk("rsp_rdata", rsp_rdata,
                        e.rw ? rd_value(e.addr) : 8'h00);
                end
            end

            c1_fe = c1_csb && !c1_prev_csb;
            if (!c1_csb) begin
                if (c1_prev_csb) begin
                    c1_low = 0;
                    c1_rises = 0;
                    c1_frame = '0;
                end
                c1_low++;
                if (c1_sclk && !c1_prev_sclk) begin
                    c1_frame = {c1_frame[22:0], c1_sdio_o};
                    c1_rises++;
                end
            end
            chk("c1_rsp_valid_at_frame_end", c1_rsp_valid, c1_fe);
            if (c1_fe) begin
                c1_last_frame = c1_frame;
                c1_last_low = c1_low;
                c1_last_rises = c1_rises;
                c1_last_rdata = c1_rsp_rdata;
                c1_rsp_count++;
            end
        end
        prev_csb = csb;
        prev_sclk = sclk;
        prev_sdio = sdio_o;
        c1_prev_csb = c1_csb;
        c1_prev_sclk = c1_sclk;
        prev_rstn = rst_n;
    end

    task automatic send(input logic rw, input logic [12:0] a,
                        input logic [7:0] d, input bit keep);
        int n;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 2000);
        chk("accept_timeout", n < 2000, 1);
        @(posedge clk);
        #1;
        exp_q.push_back('{rw, a, d});
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", rsp_count >= target, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        idle(3);
        @(negedge clk);
        chk("rst_csb", csb, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdio_o", sdio_o, 0);
        chk("rst_sdio_oe", sdio_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("c1_rst_csb", c1_csb, 1);
        chk("c1_rst_cmd_ready", c1_ready, 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_still_low", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_release", cmd_ready, 1);
        chk("busy_after_release", busy, 0);
        idle(2);

        // Single write.
        base = rsp_count;
        send(1'b0, 13'h014, 8'h01, 0);
        wait_rsp(base + 1);
        chk("wr_frame_literal", last_frame, 24'h001401);
        chk("wr_csb_low_literal", last_low, 196);
        chk("wr_rises_literal", last_rises, 24);
        chk("wr_rdata_literal", last_rdata, 8'h00);
        idle(8);

        // Reads.
        base = rsp_count;
        send(1'b1, 13'h001, 8'hFF, 0);
        wait_rsp(base + 1);
        chk("rd_instr_literal", last_frame[23:8], 16'h8001);
        chk("rd_rdata_literal", last_rdata, 8'h82);
        idle(8);
        base = rsp_count;
        send(1'b1, 13'h0FF, 8'h00, 0);
        wait_rsp(base + 1);
        chk("rd2_rdata_literal", last_rdata, 8'h5A);
        idle(8);

        // Back-to-back writes with valid held high.
        base = rsp_count;
        send(1'b0, 13'h008, 8'h03, 1);
        send(1'b0, 13'h1FFF, 8'hA5, 0);
        wait_rsp(base + 2);
        chk("b2b_last_frame_literal", last_frame, 24'h1FFFA5);
        chk("b2b_queue_drained", exp_q.size(), 0);
        idle(8);

        // Inputs wiggled while busy must not disturb the frame.
        base = rsp_count;
        send(1'b0, 13'h0AA, 8'h3C, 0);
        idle(80);
        cmd_rw = 1'b1;
        cmd_addr = 13'h1555;
        cmd_wdata = 8'hFF;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("busy_ready_low", cmd_ready, 0);
            chk("busy_high", busy, 1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(base + 1);
        chk("iso_frame_literal", last_frame, 24'h00AA3C);
        idle(300);
        chk("iso_no_extra_txn", rsp_count, base + 1);
        chk("iso_ready_back", cmd_ready, 1);

        // Reset during bit 10 of a read.
        base = rsp_count;
        send(1'b1, 13'h001, 8'h00, 0);
        n = 0;
        while (m_rises < 13 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit10", m_rises >= 13, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_csb", csb, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_sdio_oe", sdio_oe, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(50);
        chk("mid_rst_no_rsp", rsp_count, base);
        send(1'b1, 13'h001, 8'h00, 0);
        wait_rsp(base + 1);
        chk("post_rst_rdata_literal", last_rdata, 8'h82);
        idle(8);

        // CLK_DIV = 1 instance.
        base = c1_rsp_count;
        c1_rw = 1'b0;
        c1_addr = 13'h018;
        c1_wdata = 8'h04;
        c1_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c1_ready && n < 2000);
        chk("c1_accept_timeout", n < 2000, 1);
        @(posedge clk);
        #1;
        c1_valid = 1'b0;
        n = 0;
        while (c1_rsp_count < base + 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("c1_rsp_timeout", c1_rsp_count, base + 1);
        chk("c1_frame_literal", c1_last_frame, 24'h001804);
        chk("c1_csb_low_literal", c1_last_low, 52);
        chk("c1_rises_literal", c1_last_rises, 24);
        chk("c1_rdata_literal", c1_last_rdata, 8'h00);
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
